// File: rtl/edge_bbox_stats.sv
// Per-frame edge-pixel count and bounding box on the binary Sobel stream.
// Optional ROI gating is built when EDGE_BBOX_ROI_EN is defined.
module edge_bbox_stats #(
  parameter logic [15:0] IMG_HDISP = 16'd640,
  parameter logic [15:0] IMG_VDISP = 16'd480,
  parameter int unsigned CNT_W     = 20,
  parameter logic [15:0] ROI_X0    = 16'd0,
  parameter logic [15:0] ROI_X1    = 16'd639,
  parameter logic [15:0] ROI_Y0    = 16'd0,
  parameter logic [15:0] ROI_Y1    = 16'd479
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Bit,
  output logic             frame_done,
  output logic             bbox_valid,
  output logic [15:0]      bbox_xmin,
  output logic [15:0]      bbox_xmax,
  output logic [15:0]      bbox_ymin,
  output logic [15:0]      bbox_ymax,
  output logic [CNT_W-1:0] edge_count,
  output logic             frame_err
);

  typedef enum logic [1:0] {WAIT_SOF, ACTIVE, LATCH} state_t;

  state_t state, state_next;

  logic             vsync_d;
  logic             href_d;
  logic             vsync_rise;
  logic             href_fall;
  logic             pix;
  logic             hit;
  logic [15:0]      x_cnt;
  logic [15:0]      y_cnt;
  logic             valid_w;
  logic [15:0]      xmin_w, xmax_w, ymin_w, ymax_w;
  logic [CNT_W-1:0] cnt_w;
  logic             err_w;

  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign href_fall  = href_d & ~per_frame_href;
  assign pix        = (state == ACTIVE) & per_frame_vsync & per_frame_href & per_frame_clken;

`ifdef EDGE_BBOX_ROI_EN
  logic in_roi;
  assign in_roi = (x_cnt >= ROI_X0) && (x_cnt <= ROI_X1) &&
                  (y_cnt >= ROI_Y0) && (y_cnt <= ROI_Y1);
  assign hit    = pix & per_img_Bit & in_roi;
`else
  assign hit    = pix & per_img_Bit;
`endif

  // vsync_d resets high so a reset released mid-frame cannot look like a SOF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b1;
      href_d  <= 1'b0;
      state   <= WAIT_SOF;
    end else begin
      vsync_d <= per_frame_vsync;
      href_d  <= per_frame_href;
      state   <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_SOF: if (vsync_rise) state_next = ACTIVE;
      ACTIVE:   if (!per_frame_vsync) state_next = LATCH;
      LATCH:    state_next = WAIT_SOF;
      default:  state_next = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      valid_w <= 1'b0;
      xmin_w  <= '0;
      xmax_w  <= '0;
      ymin_w  <= '0;
      ymax_w  <= '0;
      cnt_w   <= '0;
      err_w   <= 1'b0;
    end else if (state == LATCH || (state == WAIT_SOF && vsync_rise)) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      valid_w <= 1'b0;
      xmin_w  <= '0;
      xmax_w  <= '0;
      ymin_w  <= '0;
      ymax_w  <= '0;
      cnt_w   <= '0;
      err_w   <= 1'b0;
    end else if (state == ACTIVE) begin
      if (pix) x_cnt <= x_cnt + 16'd1;
      if (hit) begin
        valid_w <= 1'b1;
        if (!valid_w) begin
          xmin_w <= x_cnt;
          xmax_w <= x_cnt;
          ymin_w <= y_cnt;
          ymax_w <= y_cnt;
        end else begin
          if (x_cnt < xmin_w) xmin_w <= x_cnt;
          if (x_cnt > xmax_w) xmax_w <= x_cnt;
          if (y_cnt < ymin_w) ymin_w <= y_cnt;
          if (y_cnt > ymax_w) ymax_w <= y_cnt;
        end
        if (cnt_w != '1) cnt_w <= cnt_w + 1'b1;
      end
      if (per_frame_vsync && href_fall) begin
        if (x_cnt != IMG_HDISP) err_w <= 1'b1;
        x_cnt <= '0;
        y_cnt <= y_cnt + 16'd1;
      end
      if (!per_frame_vsync && (y_cnt != IMG_VDISP || per_frame_href)) err_w <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      bbox_valid <= 1'b0;
      bbox_xmin  <= '0;
      bbox_xmax  <= '0;
      bbox_ymin  <= '0;
      bbox_ymax  <= '0;
      edge_count <= '0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= (state == LATCH);
      if (state == LATCH) begin
        bbox_valid <= valid_w;
        bbox_xmin  <= xmin_w;
        bbox_xmax  <= xmax_w;
        bbox_ymin  <= ymin_w;
        bbox_ymax  <= ymax_w;
        edge_count <= cnt_w;
        frame_err  <= err_w;
      end
    end
  end

endmodule
